// File: rtl/pb_pkg.sv
// Shared constants and types for the push-button conditioner.
package pb_pkg;

  localparam int unsigned NUM_PB_DEFAULT = 10;

  typedef logic [3:0] key_code_t;

  // Debounce counter runs 0..STABLE_TICKS-1, so it needs clog2(STABLE_TICKS) bits (min 1).
  function automatic int unsigned cnt_width(input int unsigned stable_ticks);
    return (stable_ticks <= 1) ? 1 : $clog2(stable_ticks);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// One button channel: two-flop synchronizer, tick-sampled debounce counter,
// debounced level and a registered press strobe.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic tick,
  input  logic pb_raw,
  output logic pb_db,
  output logic pb_rise,
  output logic pb_edge
);

  localparam int unsigned    CntW    = cnt_width(STABLE_TICKS);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  logic [1:0]      sync_q;
  logic            pb_sync;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            db_dly_q;
  logic            edge_q;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pb_raw};
    end
  end

  assign pb_sync = sync_q[1];

  // Count consecutive disagreeing ticks; toggle the clean level when the run completes.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick) begin
      if (pb_sync == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d = '0;
        db_d  = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state, a delayed copy of the level, and the press strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
      edge_q   <= pb_rise;
    end
  end

  // Rising edge of the clean level, one cycle after it rose; registered into pb_edge
  // and also handed to the encoder so both land in the same cycle.
  assign pb_rise = db_q & ~db_dly_q;
  assign pb_db   = db_q;
  assign pb_edge = edge_q;

endmodule

// File: rtl/pb_conditioner.sv
// Push-button front end: shared tick prescaler, NUM_PB debounce channels,
// lowest-index key encoder and optional auto-repeat.
// Define PB_AUTOREPEAT_EN to build the auto-repeat logic.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int unsigned NUM_PB       = NUM_PB_DEFAULT,
  parameter int unsigned TICK_DIV     = 10000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_db,
  output logic [NUM_PB-1:0] pb_edge,
  output logic              key_valid,
  output logic [3:0]        key_code,
  output logic              key_multi
);

  localparam int unsigned      TickW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [NUM_PB-1:0] rise;
  logic              press_any, press_multi;
  key_code_t         press_code;
  logic              rpt_fire;
  logic              key_valid_q, key_valid_d;
  key_code_t         key_code_q, key_code_d;
  logic              key_multi_q, key_multi_d;

  assign tick       = (tick_cnt_q == TickLast);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // Free-running prescaler producing the shared debounce sample tick.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
    pb_debounce #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_debounce (
      .clk     (clk),
      .nrst    (nrst),
      .tick    (tick),
      .pb_raw  (pb_raw[g]),
      .pb_db   (pb_db[g]),
      .pb_rise (rise[g]),
      .pb_edge (pb_edge[g])
    );
  end

  // Lowest set index wins; scanning downward leaves the lowest one in press_code.
  always_comb begin
    press_code = '0;
    for (int i = int'(NUM_PB) - 1; i >= 0; i--) begin
      if (rise[i]) press_code = key_code_t'(i);
    end
  end

  assign press_any   = |rise;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign press_multi = |(rise & (rise - 1'b1));

`ifdef PB_AUTOREPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic            rpt_active_q, rpt_active_d;
  logic            rpt_rate_q, rpt_rate_d;
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_cnt_inc, rpt_target;
  logic            held;

  assign held        = pb_db[key_code_q];
  assign rpt_cnt_inc = rpt_cnt_q + 1'b1;
  assign rpt_target  = rpt_rate_q ? RptW'(REPEAT_RATE) : RptW'(REPEAT_DELAY);

  // Count ticks while the reported key stays down; first repeat after the delay,
  // then at the repeat rate. A new press restarts timing for the new key.
  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_rate_d   = rpt_rate_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_fire     = 1'b0;
    if (press_any) begin
      rpt_active_d = 1'b1;
      rpt_rate_d   = 1'b0;
      rpt_cnt_d    = '0;
    end else if (!rpt_active_q || !held) begin
      rpt_active_d = 1'b0;
      rpt_rate_d   = 1'b0;
      rpt_cnt_d    = '0;
    end else if (tick) begin
      if (rpt_cnt_inc == rpt_target) begin
        rpt_fire   = 1'b1;
        rpt_rate_d = 1'b1;
        rpt_cnt_d  = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_inc;
      end
    end
  end

  // Repeat state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rpt_active_q <= 1'b0;
      rpt_rate_q   <= 1'b0;
      rpt_cnt_q    <= '0;
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_rate_q   <= rpt_rate_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;

  // Repeat timing is meaningless without auto-repeat; kept elaborated so the
  // parameters remain part of the interface in every build.
  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_rpt_unused
  end
`endif

  // Next key event: presses take priority over repeats and carry the multi flag.
  always_comb begin
    key_valid_d = press_any | rpt_fire;
    key_code_d  = press_any ? press_code : key_code_q;
    key_multi_d = press_any & press_multi;
  end

  // Key event registers, aligned with pb_edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_multi_q <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_multi_q <= key_multi_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_multi = key_multi_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: table-driven vectors, directed corner sequences and
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_pb_conditioner;

  localparam int unsigned NUM_PB       = 10;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned STABLE_TICKS = 3;
  localparam int unsigned REPEAT_DELAY = 5;
  localparam int unsigned REPEAT_RATE  = 2;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [NUM_PB-1:0] pb_raw = '0;
  logic [NUM_PB-1:0] pb_db, pb_edge;
  logic              key_valid, key_multi;
  logic [3:0]        key_code;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pb_conditioner #(
    .NUM_PB       (NUM_PB),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .pb_raw    (pb_raw),
    .pb_db     (pb_db),
    .pb_edge   (pb_edge),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_multi (key_multi)
  );

  // Behavioural model: edges numbered from 1 after reset release.
  int                m_n;
  logic [NUM_PB-1:0] m_raw_log[$];
  logic [NUM_PB-1:0] m_db;
  int                m_cnt[NUM_PB];
  int                m_rose_at[NUM_PB];
  logic [NUM_PB-1:0] m_edge;
  logic              m_valid, m_multi;
  logic [3:0]        m_code;
  bit                m_rpt_on;
  int                m_rpt_ticks, m_rpt_target;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_raw_log.delete();
    m_db = '0;
    m_edge = '0;
    m_valid = 1'b0;
    m_multi = 1'b0;
    m_code = '0;
    m_rpt_on = 1'b0;
    m_rpt_ticks = 0;
    m_rpt_target = 0;
    for (int i = 0; i < NUM_PB; i++) begin
      m_cnt[i] = 0;
      m_rose_at[i] = -10;
    end
  endtask

  task automatic model_step(input logic [NUM_PB-1:0] raw);
    logic [NUM_PB-1:0] db_before;
    logic [NUM_PB-1:0] sync;
    bit                tick;
    bit                found;
    int                npress;
    db_before = m_db;
    m_n++;
    tick = (m_n % TICK_DIV) == 0;
    // Raw level seen by the debouncer lags the pin by two clock edges.
    sync = (m_n >= 3) ? m_raw_log[m_n - 3] : '0;
    if (tick) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (sync[i] == m_db[i]) begin
          m_cnt[i] = 0;
        end else begin
          m_cnt[i]++;
          if (m_cnt[i] == STABLE_TICKS) begin
            m_db[i] = ~m_db[i];
            m_cnt[i] = 0;
            if (m_db[i]) m_rose_at[i] = m_n;
          end
        end
      end
    end
    for (int i = 0; i < NUM_PB; i++) m_edge[i] = (m_rose_at[i] == m_n - 1);
    npress = $countones(m_edge);
    m_valid = (npress > 0);
    m_multi = (npress >= 2);
    found = 1'b0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (m_edge[i] && !found) begin
        m_code = 4'(i);
        found = 1'b1;
      end
    end
`ifdef PB_AUTOREPEAT_EN
    if (npress > 0) begin
      m_rpt_on = 1'b1;
      m_rpt_ticks = 0;
      m_rpt_target = REPEAT_DELAY;
    end else if (!m_rpt_on || !db_before[m_code]) begin
      m_rpt_on = 1'b0;
    end else if (tick) begin
      m_rpt_ticks++;
      if (m_rpt_ticks == m_rpt_target) begin
        m_valid = 1'b1;
        m_rpt_ticks = 0;
        m_rpt_target = REPEAT_RATE;
      end
    end
`else
    if (db_before == '1 && m_rpt_on) m_rpt_ticks = 0;
`endif
    m_raw_log.push_back(raw);
  endtask

  // One clock with the given pin levels; every output compared with the model.
  task automatic step(input logic [NUM_PB-1:0] raw);
    pb_raw = raw;
    @(posedge clk);
    model_step(raw);
    #1;
    check("pb_db", 32'(pb_db), 32'(m_db));
    check("pb_edge", 32'(pb_edge), 32'(m_edge));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_multi", 32'(key_multi), 32'(m_multi));
  endtask

  task automatic hold_reset(input int cycles);
    nrst = 1'b0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      check("rst_pb_db", 32'(pb_db), 32'h0);
      check("rst_pb_edge", 32'(pb_edge), 32'h0);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_key_code", 32'(key_code), 32'h0);
      check("rst_key_multi", 32'(key_multi), 32'h0);
    end
    nrst = 1'b1;
  endtask

  typedef struct {
    logic [NUM_PB-1:0] raw;
    int                hold;
    logic [NUM_PB-1:0] db;
    int                edges;
    logic [NUM_PB-1:0] edge_v;
    logic [3:0]        code;
    logic              multi;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int                edges, lat, cnt, exp_n, t;
    logic [NUM_PB-1:0] last_edge, rnd;
    logic              multi_seen;
    bit                fell;
    int                vq[$];

    vecs.push_back('{10'h008, 20, 10'h008, 1, 10'h008, 4'd3, 1'b0});
    vecs.push_back('{10'h000, 20, 10'h000, 0, 10'h000, 4'd3, 1'b0});
    vecs.push_back('{10'h084, 20, 10'h084, 1, 10'h084, 4'd2, 1'b1});
    vecs.push_back('{10'h004, 20, 10'h004, 0, 10'h000, 4'd2, 1'b0});
    vecs.push_back('{10'h204, 20, 10'h204, 1, 10'h200, 4'd9, 1'b0});
    vecs.push_back('{10'h000, 20, 10'h000, 0, 10'h000, 4'd9, 1'b0});

    model_reset();
    hold_reset(3);

    // Table-driven vectors.
    foreach (vecs[k]) begin
      edges = 0;
      last_edge = '0;
      multi_seen = 1'b0;
      for (int c = 0; c < vecs[k].hold; c++) begin
        step(vecs[k].raw);
        if (|pb_edge) begin
          edges++;
          last_edge = pb_edge;
        end
        if (key_valid && key_multi) multi_seen = 1'b1;
      end
      check($sformatf("vec%0d_db", k), 32'(pb_db), 32'(vecs[k].db));
      check($sformatf("vec%0d_edges", k), 32'(edges), 32'(vecs[k].edges));
      check($sformatf("vec%0d_edge_v", k), 32'(last_edge), 32'(vecs[k].edge_v));
      check($sformatf("vec%0d_code", k), 32'(key_code), 32'(vecs[k].code));
      check($sformatf("vec%0d_multi", k), 32'(multi_seen), 32'(vecs[k].multi));
    end

    // Reset mid-operation with every pin pressed.
    for (int c = 0; c < 9; c++) step(10'h3FF);
    hold_reset(4);
    step(10'h3FF);
    check("post_rst_db", 32'(pb_db), 32'h0);
    check("post_rst_valid", 32'(key_valid), 32'h0);
    for (int c = 0; c < 20; c++) step(10'h000);

    // Clean press latency and strobe alignment on channel 3.
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      step(10'h008);
      if (pb_db[3]) lat = c;
    end
    check("press_latency_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    step(10'h008);
    check("press_edge", 32'(pb_edge), 32'h008);
    check("press_valid", 32'(key_valid), 32'h1);
    check("press_code", 32'(key_code), 32'h3);
    check("press_multi", 32'(key_multi), 32'h0);

    // Release: level falls after the stable run, no strobe of any kind.
    lat = 0;
    cnt = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      step(10'h000);
      if (key_valid || |pb_edge) cnt++;
      if (!pb_db[3]) lat = c;
    end
    check("release_latency_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    check("release_no_event", 32'(cnt), 32'h0);
    for (int c = 0; c < 4; c++) begin
      step(10'h000);
      if (key_valid || |pb_edge) cnt++;
    end
    check("release_quiet", 32'(cnt), 32'h0);

    // Six-cycle glitch on channel 5 must not get through.
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step((c < 6) ? 10'h020 : 10'h000);
      if (|pb_db || |pb_edge || key_valid) cnt++;
    end
    check("glitch_rejected", 32'(cnt), 32'h0);

    // Long hold on channel 1: repeats only when auto-repeat is built.
    vq.delete();
    for (int c = 0; c < 80; c++) begin
      step(10'h002);
      if (key_valid) begin
        vq.push_back(c);
        check("hold_code", 32'(key_code), 32'h1);
        check("hold_multi", 32'(key_multi), 32'h0);
      end
    end
    check("hold_first_event", 32'(vq.size() > 0), 32'h1);
`ifdef PB_AUTOREPEAT_EN
    if (vq.size() > 0) begin
      exp_n = 1;
      t = vq[0] + int'(REPEAT_DELAY * TICK_DIV);
      while (t < 80) begin
        exp_n++;
        t += int'(REPEAT_RATE * TICK_DIV);
      end
      check("rpt_count", 32'(vq.size()), 32'(exp_n));
      for (int k = 1; k < vq.size(); k++) begin
        check($sformatf("rpt_gap%0d", k), 32'(vq[k] - vq[k-1]),
              32'((k == 1) ? REPEAT_DELAY * TICK_DIV : REPEAT_RATE * TICK_DIV));
      end
    end
`else
    exp_n = 1;
    check("rpt_count", 32'(vq.size()), 32'(exp_n));
`endif
    fell = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      step(10'h000);
      if (fell && key_valid) cnt++;
      if (!pb_db[1]) fell = 1'b1;
    end
    check("hold_released", 32'(fell), 32'h1);
    check("no_event_after_release", 32'(cnt), 32'h0);

    // Randomized pin activity against the model, with one reset in the middle.
    rnd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        hold_reset(3);
      end
      for (int i = 0; i < NUM_PB; i++) begin
        if ($urandom_range(0, 23) == 0) rnd[i] = ~rnd[i];
      end
      step(rnd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
# pb_conditioner

Push-button front end that sits directly upstream of the calculator core and drives its `pb` bus from raw breakout-board pins. It synchronizes each asynchronous button, debounces it against a shared sample tick, and produces clean levels, single-cycle press strobes, and an encoded key event. The calculator consumes only clean, glitch-free inputs, with at most one key event per press.

## Interface
Parameters:
- `NUM_PB`, 10: number of button channels.
- `TICK_DIV`, 10000: clock cycles per debounce sample tick (≥2).
- `STABLE_TICKS`, 4: consecutive disagreeing ticks required to change a debounced state (≥1).
- `REPEAT_DELAY`, 50: ticks before the first auto-repeat. Used only with `PB_AUTOREPEAT_EN`.
- `REPEAT_RATE`, 10: ticks between subsequent repeats. Used only with `PB_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous active-low reset.
- `pb_raw`  in  NUM_PB  raw asynchronous button levels; 1 = pressed.
- `pb_db`  out  NUM_PB  debounced levels.
- `pb_edge`  out  NUM_PB  one-cycle press strobe per channel.
- `key_valid`  out  1  one-cycle key event strobe.
- `key_code`  out  4  index of the reported key; held until the next event.
- `key_multi`  out  1  more than one `pb_edge` bit set in the same cycle as `key_valid`.

## Operation
- **Reset:** all outputs, synchronizer flops, tick counter, debounce counters and repeat state are cleared to 0.
- **Synchronizer:** two-flop synchronizer per channel produces `pb_sync`.
- **Tick prescaler:** a free-running counter runs 0..TICK_DIV-1. `tick` is high for one cycle when the count equals TICK_DIV-1. The first tick occurs TICK_DIV cycles after reset release.
- **Debounce, per channel, evaluated only on `tick`:**
  - If `pb_sync` == `pb_db`, the counter clears.
  - Otherwise the counter increments. When it would reach STABLE_TICKS, `pb_db` toggles and the counter clears.
  - A single-tick glitch therefore never changes `pb_db` when STABLE_TICKS > 1.
- **Edge:** `pb_edge[i]` is registered. It is 1 for exactly one cycle, the cycle after `pb_db[i]` goes 0→1. Releases produce no strobe.
- **Encoder:** in the same cycle as any `pb_edge` bit, `key_valid` = 1 and `key_code` = lowest set index.
  - `key_multi` = 1 if two or more bits are set; otherwise 0.
  - `key_code` holds its value between events.
- **Simultaneous press and release on different channels:** only presses are encoded.
- **Reset mid-debounce:** all partial counts are lost and channels restart from 0.

## Timing
- Synchronizer latency is 2 cycles.
- Press-to-`pb_db` latency ranges from 2+TICK_DIV·(STABLE_TICKS−1)+1 to 2+TICK_DIV·STABLE_TICKS+1 cycles, depending on tick phase.
- `pb_edge`, `key_valid`, `key_code` and `key_multi` follow `pb_db` by exactly 1 cycle.
- Minimum spacing between `key_valid` pulses from one channel is 2·STABLE_TICKS ticks (press, release, press).
- No backpressure: events are strobes and the consumer must sample every cycle.

## Configuration
- **`PB_AUTOREPEAT_EN` defined:**
  - While `pb_db[key_code]` stays 1 after an event, a repeat counter counts ticks.
  - At REPEAT_DELAY ticks it emits `key_valid` with the same `key_code` and `key_multi` = 0.
  - It then emits again every REPEAT_RATE ticks.
  - Repeat strobes are aligned to the cycle after `tick`; `pb_edge` is never asserted by a repeat.
  - Release of that key, or any new press event, clears the repeat counter; a new press restarts timing for the new key.
- **`PB_AUTOREPEAT_EN` undefined:**
  - No repeat logic is built and REPEAT_* are ignored.
  - `key_valid` fires only on `pb_edge` events.

## Structure
- **Package `pb_pkg`:** `NUM_PB` default constant, `key_code_t` (logic [3:0]), and the debounce counter width derived from STABLE_TICKS.
- **Sub-module `pb_debounce`:** one channel (sync flops, counter, `pb_db` flop, edge flop), instantiated NUM_PB times by generate.
- **Top level:** prescaler, encoder and repeat logic.

## Test plan
Use TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- **Reset:** assert `nrst`=0 mid-operation with `pb_raw`=10'h3FF → all outputs 0 while in reset and 0 on the first cycle after release.
- **Clean press:** hold `pb_raw[3]` high → `pb_db[3]` rises within 11–15 cycles of the input change; `pb_edge[3]`, `key_valid` and `key_code`=3 pulse one cycle later; `key_multi`=0.
- **Glitch rejection:** pulse `pb_raw[5]` high for 6 cycles → `pb_db`, `pb_edge` and `key_valid` stay 0.
- **Simultaneous press:** raise `pb_raw[2]` and `pb_raw[7]` in the same cycle → one `key_valid` with `key_code`=2 and `key_multi`=1; `pb_edge`=10'h084.
- **Release:** release channel 3 after a debounced press → `pb_db[3]` falls after 3 ticks; no `pb_edge` and no `key_valid`.
- **Auto-repeat (`PB_AUTOREPEAT_EN` defined):** hold `pb_raw[1]` → `key_valid` with `key_code`=1 at press, then 5 ticks later, then every 2 ticks. Releasing stops the repeats. With the macro undefined, only the press event occurs.
